lsz_sched: RTL and testbench
============================

Name: lsz_sched

Overview:
- Slot scheduler for the unary scaled-add datapath.
- Runs a BITWIDTH-bit step counter and, each active cycle, finds the counter's least-significant-zero bit.
- Grants that one-hot lane, so lane i receives 2^(BITWIDTH-1-i) slots per 2^BITWIDTH-cycle period, with one idle slot per period.
- Sequences a run of iLen slots with start/stall/done control and a per-lane request mask; feeds the input-select mux of the uSADD adder.

Parameters:
- BITWIDTH, 4: number of lanes and the step-counter width.
- LOGBITWIDTH, $clog2(BITWIDTH): width of the lane index.
- LENW, 16: width of the run-length input and the remaining-slot counter.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iStart  input  1  start a run; sampled only in IDLE.
- iLen  input  LENW  number of slots in the run; sampled with iStart.
- iStall  input  1  freeze the scheduler for this cycle.
- iReq  input  BITWIDTH  per-lane request mask.
- oSel  output  BITWIDTH  registered one-hot grant.
- oSelIdx  output  LOGBITWIDTH  registered index of the granted lane.
- oValid  output  1  registered; oSel/oSelIdx are a real grant this cycle.
- oGrey  output  BITWIDTH  registered Gray code of the step that produced the current outputs: cnt ^ (cnt >> 1).
- oBusy  output  1  state is RUN.
- oDone  output  1  one-cycle pulse; state is DONE.

Behaviour:
- Reset (asynchronous, iRst=1):
  - state=IDLE, cnt=0, rem=0.
  - oSel=0, oSelIdx=0, oValid=0, oGrey=0, oBusy=0, oDone=0.
  - Reset mid-run aborts the run immediately; no oDone is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - iStart=1 with iLen!=0: cnt<=0, rem<=iLen, go to RUN.
  - iStart=1 with iLen==0: go to DONE with no slots issued.
  - Otherwise hold. oValid=0.
- RUN, iStall=1:
  - cnt, rem and state hold.
  - oValid<=0; oSel, oSelIdx and oGrey hold their values.
- RUN, iStall=0 (one step):
  - z = index of the lowest 0 bit of cnt.
  - If cnt has no zero bit (cnt all ones): oSel<=0, oSelIdx<=0, oValid<=0.
  - Otherwise: oSel<=(1<<z), oSelIdx<=z, oValid<=iReq[z].
  - A masked lane's slot is dropped, not reassigned, so lane weights stay deterministic.
  - oGrey<=cnt^(cnt>>1); cnt<=cnt+1 (wraps mod 2^BITWIDTH); rem<=rem-1.
  - If rem==1: go to DONE.
- DONE:
  - Lasts exactly one cycle; oDone=1, oBusy=0.
  - The final step's outputs remain visible during this cycle.
  - Next edge: oValid<=0, oSel<=0, then go to IDLE.
  - iStart during DONE is ignored.
- Latency:
  - iStart is sampled at edge E0.
  - The first grant is visible after edge E1 (the first non-stalled RUN edge).
  - N = iLen slots are issued on N non-stalled RUN edges.
- iStart during RUN is ignored; iLen is not re-sampled.
- iStall has no effect in IDLE or DONE.
- Wrap-around: runs longer than 2^BITWIDTH repeat the pattern; cnt is never reset mid-run.
- oBusy and oDone are decoded from the state register only (glitch-free, no input paths).
- Runs where iLen is a multiple of 2^BITWIDTH give exact lane ratios.

Test Plan:
- Full period (BITWIDTH=4, iLen=16, iReq=4'b1111, no stall) -> oSelIdx sequence 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0 then an idle slot; 15 oValid pulses (lane0 8, lane1 4, lane2 2, lane3 1); oDone one cycle after the 16th step; oGrey follows 0,1,3,2,6,...
- Masking (iLen=16, iReq=4'b1010) -> oValid only on lane1/lane3 slots (5 pulses); other slots have oValid=0 with oSel still one-hot.
- Stall (iLen=4, iStall high for 3 cycles after the 2nd grant) -> outputs freeze with oValid=0; grants resume at idx 0 then 2; oDone 3 cycles later than the unstalled run.
- Zero length / ignored start (iLen=0) -> DONE next cycle, no oValid; a second iStart during RUN does not change rem.
- Wrap (iLen=40) -> the pattern repeats after step 16; oDone after the 40th step; lane0 receives 20 grants.
- Async reset mid-run (iRst asserted between edges at step 5) -> all outputs 0 immediately; IDLE; no oDone; the next iStart restarts at cnt=0.

Source files
------------

// File: rtl/lsz_sched_if.sv
// Handshake bundle between the slot scheduler and its controller.
// The controller drives run control and the request mask; the scheduler drives the grants.
interface lsz_sched_if #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH),
    parameter int LENW        = 16
);
    logic                   iStart;
    logic [LENW-1:0]        iLen;
    logic                   iStall;
    logic [BITWIDTH-1:0]    iReq;
    logic [BITWIDTH-1:0]    oSel;
    logic [LOGBITWIDTH-1:0] oSelIdx;
    logic                   oValid;
    logic [BITWIDTH-1:0]    oGrey;
    logic                   oBusy;
    logic                   oDone;

    modport master (
        output iStart, iLen, iStall, iReq,
        input  oSel, oSelIdx, oValid, oGrey, oBusy, oDone
    );

    modport slave (
        input  iStart, iLen, iStall, iReq,
        output oSel, oSelIdx, oValid, oGrey, oBusy, oDone
    );
endinterface

// File: rtl/lsz_sched.sv
// Least-significant-zero slot scheduler for the unary scaled-add adder.
// Lane i is granted 2^(BITWIDTH-1-i) times per 2^BITWIDTH steps, plus one idle slot.
module lsz_sched #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH),
    parameter int LENW        = 16
) (
    input logic          iClk,
    input logic          iRst,
    lsz_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [BITWIDTH-1:0]    cnt, cnt_n;
    logic [LENW-1:0]        rem, rem_n;
    logic [BITWIDTH-1:0]    sel, sel_n;
    logic [LOGBITWIDTH-1:0] idx, idx_n;
    logic                   valid, valid_n;
    logic [BITWIDTH-1:0]    grey, grey_n;
    logic                   found;
    logic [LOGBITWIDTH-1:0] z;

    // Scan from the top so the lowest zero bit wins.
    always_comb begin
        found = 1'b0;
        z     = '0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!cnt[i]) begin
                found = 1'b1;
                z     = LOGBITWIDTH'(i);
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            sel   <= '0;
            idx   <= '0;
            valid <= 1'b0;
            grey  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
            sel   <= sel_n;
            idx   <= idx_n;
            valid <= valid_n;
            grey  <= grey_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        sel_n   = sel;
        idx_n   = idx;
        valid_n = valid;
        grey_n  = grey;
        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (bus.iStart) begin
                    if (bus.iLen != '0) begin
                        cnt_n   = '0;
                        rem_n   = bus.iLen;
                        state_n = RUN;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                if (bus.iStall) begin
                    valid_n = 1'b0;
                end else begin
                    // The all-ones step is the idle slot of each period.
                    if (found) begin
                        sel_n   = BITWIDTH'(1) << z;
                        idx_n   = z;
                        valid_n = bus.iReq[z];
                    end else begin
                        sel_n   = '0;
                        idx_n   = '0;
                        valid_n = 1'b0;
                    end
                    grey_n = cnt ^ (cnt >> 1);
                    cnt_n  = cnt + BITWIDTH'(1);
                    rem_n  = rem - LENW'(1);
                    if (rem == LENW'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                valid_n = 1'b0;
                sel_n   = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.oSel    = sel;
    assign bus.oSelIdx = idx;
    assign bus.oValid  = valid;
    assign bus.oGrey   = grey;
    assign bus.oBusy   = (state == RUN);
    assign bus.oDone   = (state == DONE);
endmodule

// File: tb/tb_lsz_sched.sv
// Scoreboard bench for lsz_sched: the driver predicts grants from the slot rule,
// a negedge monitor pops and compares whenever the DUT shows oValid or oDone.
module tb_lsz_sched;
    localparam int BW = 4;
    localparam int LW = 16;

    typedef struct {
        int           cyc;
        int           idx;
        logic [BW-1:0] sel;
        logic [BW-1:0] grey;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    lsz_sched_if #(.BITWIDTH(BW), .LOGBITWIDTH(2), .LENW(LW)) bus();

    lsz_sched #(.BITWIDTH(BW), .LOGBITWIDTH(2), .LENW(LW)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t gq[$];
    int   dq[$];
    int   m_chk = 0, m_err = 0;
    int   d_chk = 0, d_err = 0;
    int   lane_cnt[BW];
    int   last_done = -1;
    int   start_cyc = 0;

    function automatic bit chk(string name, int act, int req);
        if (act != req)
            $display("FAIL %s: got %0d required %0d", name, act, req);
        return act == req;
    endfunction

    // Number of trailing ones of the step = lane that owns it.
    function automatic int lane_of(int s);
        int v = s;
        int n = 0;
        while (v % 2 == 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    initial for (int i = 0; i < BW; i++) lane_cnt[i] = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.oValid) begin
                m_chk++;
                if (gq.size() == 0) begin
                    m_err++;
                    $display("FAIL unexpected_valid: got idx %0d at cycle %0d required none",
                             bus.oSelIdx, cyc);
                end else begin
                    exp_t e;
                    e = gq.pop_front();
                    if (!chk("grant_cycle", cyc, e.cyc)) m_err++;
                    m_chk++;
                    if (!chk("grant_idx", int'(bus.oSelIdx), e.idx)) m_err++;
                    m_chk++;
                    if (!chk("grant_sel", int'(bus.oSel), int'(e.sel))) m_err++;
                    m_chk++;
                    if (!chk("grant_grey", int'(bus.oGrey), int'(e.grey))) m_err++;
                end
                lane_cnt[bus.oSelIdx] = lane_cnt[bus.oSelIdx] + 1;
            end
            if (bus.oDone) begin
                m_chk++;
                if (dq.size() == 0) begin
                    m_err++;
                    $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
                end else begin
                    if (!chk("done_cycle", cyc, dq.pop_front())) m_err++;
                end
                m_chk++;
                if (!chk("done_busy", int'(bus.oBusy), 0)) m_err++;
                last_done = cyc;
            end
        end
    end

    task automatic run_seq(input int len, input logic [BW-1:0] req, input bit rreq,
                           input int pct, input int st_at, input int st_n,
                           input bit poke, input int abort_at);
        int k = 0;
        int c = 0;
        logic [BW-1:0] r;
        bit st;
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iLen   = LW'(len);
        bus.iReq   = req;
        bus.iStall = 1'($urandom_range(0, 1));
        start_cyc  = cyc + 1;
        if (len == 0) begin
            dq.push_back(cyc + 1);
        end
        while (k < len && !(abort_at > 0 && k == abort_at)) begin
            @(negedge clk);
            st = (c >= st_at && c < st_at + st_n) || ($urandom_range(0, 99) < pct);
            r  = rreq ? BW'($urandom) : req;
            bus.iStall = st;
            bus.iReq   = r;
            bus.iStart = poke && ($urandom_range(0, 3) == 0);
            bus.iLen   = LW'($urandom);
            if (!st) begin
                int s = k % (1 << BW);
                int z = lane_of(s);
                if (z < BW && r[z]) begin
                    exp_t e;
                    e.cyc  = cyc + 1;
                    e.idx  = z;
                    e.sel  = BW'(1 << z);
                    e.grey = BW'(s ^ (s >> 1));
                    gq.push_back(e);
                end
                k++;
                if (k == len) dq.push_back(cyc + 1);
            end
            c++;
        end
        @(negedge clk);
        bus.iStall = 1'b0;
        if (abort_at > 0) begin
            bus.iStart = 1'b0;
            #2 rst = 1'b1;
            #1;
            d_chk++; if (!chk("rst_sel", int'(bus.oSel), 0)) d_err++;
            d_chk++; if (!chk("rst_valid", int'(bus.oValid), 0)) d_err++;
            d_chk++; if (!chk("rst_grey", int'(bus.oGrey), 0)) d_err++;
            d_chk++; if (!chk("rst_busy", int'(bus.oBusy), 0)) d_err++;
            d_chk++; if (!chk("rst_done", int'(bus.oDone), 0)) d_err++;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            // Start while DONE is showing must be ignored.
            bus.iStart = 1'b1;
            bus.iLen   = LW'(3);
            @(negedge clk);
            bus.iStart = 1'b0;
        end
    endtask

    int snap[BW];
    task automatic take_snap();
        for (int i = 0; i < BW; i++) snap[i] = lane_cnt[i];
    endtask

    initial begin
        int errors;
        bus.iStart = 1'b0;
        bus.iLen   = '0;
        bus.iStall = 1'b0;
        bus.iReq   = '0;
        repeat (2) @(negedge clk);
        d_chk++; if (!chk("reset_sel", int'(bus.oSel), 0)) d_err++;
        d_chk++; if (!chk("reset_idx", int'(bus.oSelIdx), 0)) d_err++;
        d_chk++; if (!chk("reset_valid", int'(bus.oValid), 0)) d_err++;
        d_chk++; if (!chk("reset_busy", int'(bus.oBusy), 0)) d_err++;
        rst = 1'b0;
        @(negedge clk);

        take_snap();
        run_seq(16, 4'b1111, 0, 0, 0, 0, 0, 0);
        d_chk++; if (!chk("full_lane0", lane_cnt[0] - snap[0], 8)) d_err++;
        d_chk++; if (!chk("full_lane1", lane_cnt[1] - snap[1], 4)) d_err++;
        d_chk++; if (!chk("full_lane2", lane_cnt[2] - snap[2], 2)) d_err++;
        d_chk++; if (!chk("full_lane3", lane_cnt[3] - snap[3], 1)) d_err++;

        take_snap();
        run_seq(16, 4'b1010, 0, 0, 0, 0, 0, 0);
        d_chk++; if (!chk("mask_lane0", lane_cnt[0] - snap[0], 0)) d_err++;
        d_chk++; if (!chk("mask_lane1", lane_cnt[1] - snap[1], 4)) d_err++;
        d_chk++; if (!chk("mask_lane3", lane_cnt[3] - snap[3], 1)) d_err++;

        run_seq(4, 4'b1111, 0, 0, 0, 0, 0, 0);
        d_chk++; if (!chk("nostall_len", last_done - start_cyc, 4)) d_err++;
        run_seq(4, 4'b1111, 0, 0, 2, 3, 0, 0);
        d_chk++; if (!chk("stall_len", last_done - start_cyc, 7)) d_err++;

        run_seq(0, 4'b1111, 0, 0, 0, 0, 0, 0);
        d_chk++; if (!chk("zero_len", last_done - start_cyc, 0)) d_err++;
        run_seq(10, 4'b1111, 0, 0, 0, 0, 1, 0);

        take_snap();
        run_seq(40, 4'b1111, 0, 0, 0, 0, 0, 0);
        d_chk++; if (!chk("wrap_lane0", lane_cnt[0] - snap[0], 20)) d_err++;
        d_chk++; if (!chk("wrap_len", last_done - start_cyc, 40)) d_err++;

        run_seq(20, 4'b1111, 0, 0, 0, 0, 0, 5);
        run_seq(5, 4'b1111, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 8; t++)
            run_seq($urandom_range(0, 50), 4'b0000, 1, 30, 0, 0, 1, 0);

        repeat (4) @(negedge clk);
        d_chk++; if (!chk("grants_left", gq.size(), 0)) d_err++;
        d_chk++; if (!chk("dones_left", dq.size(), 0)) d_err++;
        errors = m_err + d_err;
        $display("Result: errors=%0d of %0d checks", errors, m_chk + d_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end
endmodule
